// File: rtl/debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module   : debounce_fsm
// Purpose  : Two-flop synchroniser followed by a Moore debounce FSM with a
//            stability counter; produces a clean level for an edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_fsm #(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_in,
    output logic       db_out,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [1:0] c_ZERO  = 2'b00;
    localparam logic [1:0] c_WAIT1 = 2'b01;
    localparam logic [1:0] c_ONE   = 2'b10;
    localparam logic [1:0] c_WAIT0 = 2'b11;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Any sample disagreeing with the pending level drops back to the settled state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            c_ZERO: begin
                if (r_sync2) begin
                    w_state_nxt = c_WAIT1;
                    w_cnt_nxt   = '0;
                end
            end
            c_WAIT1: begin
                if (!r_sync2) begin
                    w_state_nxt = c_ZERO;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = c_ONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            c_ONE: begin
                if (!r_sync2) begin
                    w_state_nxt = c_WAIT0;
                    w_cnt_nxt   = '0;
                end
            end
            c_WAIT0: begin
                if (r_sync2) begin
                    w_state_nxt = c_ONE;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = c_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ZERO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ZERO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign db_out    = (r_state == c_ONE) || (r_state == c_WAIT0);
    assign dbg_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_fsm
// Purpose  : Randomised plus directed bench for debounce_fsm with a queued
//            reference model and a decoupled output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_fsm;

    localparam int STABLE = 4;

    logic       clk;
    logic       rst;
    logic       sw_in;
    logic       db_out;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    debounce_fsm #(.STABLE_CYCLES(STABLE)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .db_out    (db_out),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: level flips once STABLE+1 consecutive synchronised samples
    // disagree with it; the synchroniser is a two-sample delay line.
    logic       m_d1, m_d2, m_db;
    int         m_run;
    logic [2:0] exp_q[$];

    function automatic logic [1:0] exp_state(input logic db, input int run);
        if (!db) return (run == 0) ? 2'b00 : 2'b01;
        else     return (run == 0) ? 2'b10 : 2'b11;
    endfunction

    task automatic model_reset();
        m_d1  = 1'b0;
        m_d2  = 1'b0;
        m_db  = 1'b0;
        m_run = 0;
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        logic s;
        if (!rst) begin
            s    = m_d2;
            m_d2 = m_d1;
            m_d1 = sw_in;
            if (s != m_db) begin
                m_run++;
                if (m_run == STABLE + 1) begin
                    m_db  = ~m_db;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            exp_q.push_back({m_db, exp_state(m_db, m_run)});
        end
    end

    always @(posedge clk) begin
        logic [2:0] e;
        #1;
        if (!rst) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty got %b_%b required queued entry", db_out, dbg_state);
            end else begin
                e = exp_q.pop_front();
                if ({db_out, dbg_state} !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got db=%b st=%b required db=%b st=%b",
                             $time, db_out, dbg_state, e[2], e[1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %b required %b", name, got, req);
        end
    endtask

    // Drive at negedge, return just after the following rising edge.
    task automatic cyc(input logic v);
        @(negedge clk);
        sw_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset", {db_out, dbg_state}, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit saw01, saw_high;
        logic prev;
        int pulses;
        rst   = 1'b1;
        sw_in = 1'b0;
        model_reset();
        #1;
        check("reset_state", {db_out, dbg_state}, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc(1'b0);

        // Clean press
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        check("press_wait_entry", {db_out, dbg_state}, 3'b001);
        repeat (3) cyc(1'b1);
        check("press_not_early", {db_out, dbg_state}, 3'b001);
        cyc(1'b1);
        check("press_done", {db_out, dbg_state}, 3'b110);

        // Clean release
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        check("release_wait", {db_out, dbg_state}, 3'b111);
        repeat (3) cyc(1'b0);
        check("release_hold", {db_out, dbg_state}, 3'b111);
        cyc(1'b0);
        check("release_done", {db_out, dbg_state}, 3'b000);
        repeat (3) cyc(1'b0);

        // Bounce on press: 3 high, 1 low, then held high
        repeat (3) cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        repeat (5) cyc(1'b1);
        check("bounce_not_early", {2'b00, db_out}, 3'b000);
        cyc(1'b1);
        check("bounce_rise", {2'b00, db_out}, 3'b001);

        // Reset from ONE with sw held high, then re-qualify from scratch
        repeat (3) cyc(1'b1);
        do_reset();
        repeat (5) cyc(1'b1);
        check("requal_not_early", {2'b00, db_out}, 3'b000);
        repeat (2) cyc(1'b1);
        check("requal_rise", {2'b00, db_out}, 3'b001);
        repeat (10) cyc(1'b0);

        // Short glitch from ZERO
        saw01 = 0;
        saw_high = 0;
        cyc(1'b1);
        cyc(1'b1);
        repeat (8) begin
            cyc(1'b0);
            if (dbg_state == 2'b01) saw01 = 1;
            if (db_out) saw_high = 1;
        end
        check("glitch_visit_wait", {2'b00, saw01}, 3'b001);
        check("glitch_no_output", {2'b00, saw_high}, 3'b000);
        check("glitch_final", {db_out, dbg_state}, 3'b000);

        // Bouncy press feeding an edge detector: exactly one pulse
        prev = db_out;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            pulses += int'(db_out & ~prev); prev = db_out;
            cyc(1'b0);
            pulses += int'(db_out & ~prev); prev = db_out;
        end
        repeat (14) begin
            cyc(1'b1);
            pulses += int'(db_out & ~prev); prev = db_out;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL edge_pulse_count got %0d required 1", pulses);
        end

        // Randomised bouncing with occasional long holds and resets
        for (int seg = 0; seg < 500; seg++) begin
            logic v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 5));
            repeat (len) cyc(v);
            if (seg % 97 == 96) do_reset();
        end

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
Input-conditioning stage that sits directly upstream of the edge detector. It takes a raw, asynchronous, bouncing switch or button line and synchronises it into the clock domain with two flops. It then filters it through a Moore state machine with a stability counter. The debounced level db_out drives the edge detector's input, so that stage sees exactly one clean transition per physical press or release.

Parameters:
STABLE_CYCLES, 1000, number of consecutive clk cycles the synchronised input must hold a new level before db_out follows; legal range >= 1.
CNT_W, $clog2(STABLE_CYCLES+1), stability counter width (localparam, derived, not overridable).

Ports:
clk  input  1  single system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset; clears all flops immediately
sw_in  input  1  raw asynchronous switch level, may bounce or glitch
db_out  output  1  debounced level, Moore output decoded from state only
dbg_state  output  2  current state encoding, for debug/LED display

Behaviour:
- Interface: one clock clk. Reset rst is asynchronous and active-high. No other clocks or enables.
- Synchroniser:
  - Two flop chain sync1 <= sw_in, sync2 <= sync1. sw_sync = sync2.
  - Both flops reset to 0.
  - The FSM never samples sw_in directly.
- State encoding (enum in a package, 2 bits): ZERO=2'b00, WAIT1=2'b01, ONE=2'b10, WAIT0=2'b11.
- dbg_state = state register, unmodified.
- Counter cnt, CNT_W bits, resets to 0. It only advances in WAIT1/WAIT0.
- Transitions, evaluated each rising edge:
  - ZERO: if sw_sync=1 -> WAIT1, cnt<=0. Else stay.
  - WAIT1: if sw_sync=0 -> ZERO (bounce rejected). Else if cnt==STABLE_CYCLES-1 -> ONE. Else cnt<=cnt+1.
  - ONE: if sw_sync=0 -> WAIT0, cnt<=0. Else stay.
  - WAIT0: if sw_sync=1 -> ONE (bounce rejected). Else if cnt==STABLE_CYCLES-1 -> ZERO. Else cnt<=cnt+1.
- Output decoding:
  - db_out = 1 in ONE and WAIT0; 0 in ZERO and WAIT1.
  - Purely a function of state; no combinational path from sw_in.
- Latency:
  - sw_in changes and then stays stable before rising edge 0.
  - db_out changes after rising edge STABLE_CYCLES+2, i.e. the (STABLE_CYCLES+3)th edge.
  - This is 2 cycles of synchroniser, 1 cycle to enter WAIT, and STABLE_CYCLES cycles counting.
- Boundary conditions:
  - Any sync-domain pulse shorter than STABLE_CYCLES+1 cycles produces no db_out change.
  - Any bounce restarts the count from 0 on the next WAIT entry.
  - cnt never exceeds STABLE_CYCLES-1, so no wrap-around.
  - STABLE_CYCLES=1: WAIT state lasts exactly one cycle when the input is stable.
- Reset values:
  - db_out=0, dbg_state=2'b00, cnt=0, sync1=sync2=0.
- Reset mid-operation:
  - From any state (including ONE with sw_in held high), rst forces ZERO, db_out=0 and the sync flops to 0 asynchronously.
  - After release, a held-high sw_in is re-qualified from scratch (full latency again).
- Unique case over state; an illegal encoding is impossible with 4 encodings and 2 bits.

Test Plan:
(All with STABLE_CYCLES=4.)
- Reset: assert rst asynchronously mid-cycle with sw_in=1 and state ONE -> db_out=0 and dbg_state=2'b00 before the next clk edge.
- Clean press: sw_in 0->1 before edge 0 and held -> dbg_state=01 after edge 2; db_out=1 and dbg_state=10 after edge 6, not earlier.
- Bounce on press: sw_in high 3 cycles, low 1, high held -> db_out stays 0 through the glitch. It rises 7 edges after the final rising transition of sw_in.
- Clean release from ONE: sw_in 1->0 held -> dbg_state=11 with db_out=1 for 4 cycles, then db_out=0 and dbg_state=00 after edge 6.
- Short glitch: 2-cycle high pulse on sw_in while in ZERO -> db_out never leaves 0; dbg_state visits 01 then returns to 00.
- Chained with the edge detector: one bouncy press (5 bounces) -> the downstream pulse output is high for exactly 1 cycle.
